// File: rtl/ptr_loop_ctrl.sv
// Row-major 2-D pointer traversal controller: loads row/column pointers, then
// walks every element, stepping the column pointer and wrapping rows.
module ptr_loop_ctrl (
    input  logic       Clk,
    input  logic       RST,
    input  logic       start,
    input  logic       abort,
    input  logic       step,
    input  logic [7:0] row_base,
    input  logic [7:0] col_base,
    input  logic [7:0] n_rows,
    input  logic [7:0] n_cols,
    output logic [7:0] load_data,
    output logic       rp_wen,
    output logic       rp_inc,
    output logic       cp_wen,
    output logic       cp_inc,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] row_idx,
    output logic [7:0] col_idx,
    output logic       last_elem
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_R, S_LOAD_C, S_RUN, S_ROW_WRAP, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] row_base_q, row_base_d;
    logic [7:0] col_base_q, col_base_d;
    logic [7:0] n_rows_q, n_rows_d;
    logic [7:0] n_cols_q, n_cols_d;
    logic [7:0] row_idx_q, row_idx_d;
    logic [7:0] col_idx_q, col_idx_d;
    logic       err_q, err_d;
    logic       row_last, col_last, live;

    assign row_last = (row_idx_q == n_rows_q - 8'd1);
    assign col_last = (col_idx_q == n_cols_q - 8'd1);

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q    <= S_IDLE;
            row_base_q <= '0;
            col_base_q <= '0;
            n_rows_q   <= '0;
            n_cols_q   <= '0;
            row_idx_q  <= '0;
            col_idx_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            col_base_q <= col_base_d;
            n_rows_q   <= n_rows_d;
            n_cols_q   <= n_cols_d;
            row_idx_q  <= row_idx_d;
            col_idx_q  <= col_idx_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        col_base_d = col_base_q;
        n_rows_d   = n_rows_q;
        n_cols_d   = n_cols_q;
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        err_d      = 1'b0;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (n_rows == 8'd0 || n_cols == 8'd0) begin
                            err_d = 1'b1;
                        end else begin
                            row_base_d = row_base;
                            col_base_d = col_base;
                            n_rows_d   = n_rows;
                            n_cols_d   = n_cols;
                            row_idx_d  = '0;
                            col_idx_d  = '0;
                            state_d    = S_LOAD_R;
                        end
                    end
                end
                S_LOAD_R: state_d = S_LOAD_C;
                S_LOAD_C: state_d = S_RUN;
                S_RUN: begin
                    if (step) begin
                        if (!col_last)      col_idx_d = col_idx_q + 8'd1;
                        else if (!row_last) state_d   = S_ROW_WRAP;
                        else                state_d   = S_DONE;
                    end
                end
                S_ROW_WRAP: begin
                    row_idx_d = row_idx_q + 8'd1;
                    col_idx_d = '0;
                    state_d   = S_RUN;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are suppressed in any cycle that is about to be cancelled.
    assign live = !RST && !abort;

    always_comb begin
        load_data = '0;
        rp_wen    = 1'b0;
        rp_inc    = 1'b0;
        cp_wen    = 1'b0;
        cp_inc    = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_LOAD_R: begin
                rp_wen    = live;
                load_data = live ? row_base_q : 8'd0;
            end
            S_LOAD_C: begin
                cp_wen    = live;
                load_data = live ? col_base_q : 8'd0;
            end
            S_RUN:      cp_inc = live && step && !col_last;
            S_ROW_WRAP: begin
                cp_wen    = live;
                rp_inc    = live;
                load_data = live ? col_base_q : 8'd0;
            end
            S_DONE:  done = live;
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign row_idx   = row_idx_q;
    assign col_idx   = col_idx_q;
    assign last_elem = (state_q == S_RUN) && row_last && col_last;

endmodule

// File: tb/tb_ptr_loop_ctrl.sv
// Randomized bench for ptr_loop_ctrl: a row-major element walker model plus
// an external pointer-register model driven from the DUT strobes.
module tb_ptr_loop_ctrl;

    logic       Clk = 1'b0;
    logic       RST, start, abort, step;
    logic [7:0] row_base, col_base, n_rows, n_cols;
    logic [7:0] load_data, row_idx, col_idx;
    logic       rp_wen, rp_inc, cp_wen, cp_inc, busy, done, err, last_elem;

    int checks = 0;
    int errors = 0;
    logic [7:0] rp_m = 8'h0, cp_m = 8'h0;

    ptr_loop_ctrl dut (
        .Clk(Clk), .RST(RST), .start(start), .abort(abort), .step(step),
        .row_base(row_base), .col_base(col_base), .n_rows(n_rows), .n_cols(n_cols),
        .load_data(load_data), .rp_wen(rp_wen), .rp_inc(rp_inc), .cp_wen(cp_wen),
        .cp_inc(cp_inc), .busy(busy), .done(done), .err(err),
        .row_idx(row_idx), .col_idx(col_idx), .last_elem(last_elem)
    );

    always #5 Clk = ~Clk;

    // Pointer registers as the surrounding datapath would hold them
    always @(negedge Clk) begin
        if (rp_wen) rp_m <= load_data;
        else if (rp_inc) rp_m <= rp_m + 8'd1;
        if (cp_wen) cp_m <= load_data;
        else if (cp_inc) cp_m <= cp_m + 8'd1;
    end

    // {row_idx, col_idx, load_data, last_elem, rp_wen, rp_inc, cp_wen, cp_inc, done, err, busy}
    function automatic logic [31:0] obs();
        return {row_idx, col_idx, load_data, last_elem, rp_wen, rp_inc, cp_wen, cp_inc, done, err, busy};
    endfunction

    task automatic scramble();
        start    = 1'($urandom_range(1));
        row_base = 8'($urandom);
        col_base = 8'($urandom);
        n_rows   = 8'(($urandom_range(2) == 0) ? 0 : $urandom);
        n_cols   = 8'(($urandom_range(2) == 0) ? 0 : $urandom);
    endtask

    // mode: 0 none, 1 abort on first row wrap, 2 abort at random, 3 RST at random
    task automatic trav(input logic [7:0] rb, input logic [7:0] cb, input int R, input int C,
                        input int step_pct, input int stall_n, input int mode, output int cyc);
        int r, c, stalls;
        bit wrap, fin, kill;
        r = 0; c = 0; stalls = 0; wrap = 0; fin = 0; kill = 0; cyc = -1;
        @(posedge Clk); #1;
        start = 1'b1; abort = 1'b0; row_base = rb; col_base = cb;
        n_rows = 8'(R); n_cols = 8'(C);
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL pre_accept_busy: got %b exp 0", busy); end
        @(posedge Clk); #1; scramble();
        @(negedge Clk);
        checks++;
        if (obs() !== {16'h0, rb, 8'b0100_0001}) begin
            errors++; $display("FAIL load_r: got %h exp %h", obs(), {16'h0, rb, 8'b0100_0001});
        end
        @(posedge Clk); #1; scramble();
        @(negedge Clk);
        checks++;
        if (obs() !== {16'h0, cb, 8'b0001_0001}) begin
            errors++; $display("FAIL load_c: got %h exp %h", obs(), {16'h0, cb, 8'b0001_0001});
        end
        cyc = 2;
        while (!fin && !kill && cyc < 3000) begin
            @(posedge Clk); #1; scramble();
            cyc++;
            step = (int'($urandom_range(99)) < step_pct);
            if (stall_n > 0 && c == 1 && !wrap && stalls < stall_n) begin step = 1'b0; stalls++; end
            kill = (mode == 1 && wrap) || (mode >= 2 && !wrap && $urandom_range(7) == 0);
            if (kill && mode == 3) RST = 1'b1;
            else if (kill) abort = 1'b1;
            @(negedge Clk);
            if (kill) begin
                if (mode != 3) begin
                    checks++;
                    if ({obs()[15:8], obs()[6:0]} !== 15'h0001) begin
                        errors++; $display("FAIL abort_quiet: got %h exp 0001", {obs()[15:8], obs()[6:0]});
                    end
                end
                @(posedge Clk); #1;
                RST = 1'b0; abort = 1'b0; start = 1'b0;
                @(negedge Clk);
                checks++;
                if (mode == 3) begin
                    if (obs() !== 32'h0) begin errors++; $display("FAIL rst_outputs: got %h exp 0", obs()); end
                end else if (obs()[15:0] !== 16'h0) begin
                    errors++; $display("FAIL abort_idle: got %h exp 0", obs()[15:0]);
                end
            end else if (wrap) begin
                checks++;
                if (obs() !== {8'(r), 8'(C - 1), cb, 8'b0011_0001}) begin
                    errors++; $display("FAIL row_wrap: got %h exp %h", obs(), {8'(r), 8'(C - 1), cb, 8'b0011_0001});
                end
                wrap = 0; r++; c = 0;
            end else begin
                checks++;
                if ({obs(), rp_m, cp_m} !== {8'(r), 8'(c), 8'h0, (r == R - 1 && c == C - 1), 3'b000,
                                             (step && c != C - 1), 3'b001, rb + 8'(r), cb + 8'(c)}) begin
                    errors++;
                    $display("FAIL run r=%0d c=%0d: got %h exp %h", r, c, {obs(), rp_m, cp_m},
                             {8'(r), 8'(c), 8'h0, (r == R - 1 && c == C - 1), 3'b000,
                              (step && c != C - 1), 3'b001, rb + 8'(r), cb + 8'(c)});
                end
                if (step) begin
                    if (c != C - 1) c++;
                    else if (r != R - 1) wrap = 1;
                    else fin = 1;
                end
            end
        end
        if (!fin && !kill) begin
            errors++; $display("FAIL timeout: traversal did not finish in %0d cycles", cyc);
        end
        if (fin) begin
            @(posedge Clk); #1; scramble(); step = 1'($urandom_range(1));
            cyc++;
            @(negedge Clk);
            checks++;
            if (obs() !== {8'(R - 1), 8'(C - 1), 16'h0005}) begin
                errors++; $display("FAIL done_pulse: got %h exp %h", obs(), {8'(R - 1), 8'(C - 1), 16'h0005});
            end
            @(posedge Clk); #1; start = 1'b0;
            @(negedge Clk);
            checks++;
            if (obs()[15:0] !== 16'h0) begin errors++; $display("FAIL after_done: got %h exp 0", obs()[15:0]); end
        end
        if (kill) cyc = -1;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b1; abort = 1'b0; step = 1'b1;
        row_base = 8'h11; col_base = 8'h22; n_rows = 8'd2; n_cols = 8'd2;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (obs() !== 32'h0) begin errors++; $display("FAIL reset_state: got %h exp 0", obs()); end
        @(posedge Clk); #1; RST = 1'b0; start = 1'b0;
    endtask

    task automatic test_directed();
        int cyc;
        trav(8'h10, 8'h20, 2, 3, 100, 0, 0, cyc);
        checks++;
        if (cyc !== 10) begin errors++; $display("FAIL directed_latency: got %0d exp 10", cyc); end
    endtask

    task automatic test_err();
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk); #1;
            start = 1'b1;
            n_rows = (k == 0) ? 8'd3 : 8'd0;
            n_cols = (k == 0) ? 8'd0 : 8'd5;
            @(negedge Clk);
            checks++;
            if (obs()[15:0] !== 16'h0) begin errors++; $display("FAIL err_early: got %h exp 0", obs()[15:0]); end
            @(posedge Clk); #1; start = 1'b0;
            @(negedge Clk);
            checks++;
            if (obs()[15:0] !== 16'h0002) begin errors++; $display("FAIL err_pulse: got %h exp 0002", obs()[15:0]); end
            @(posedge Clk); #1;
            @(negedge Clk);
            checks++;
            if (obs()[15:0] !== 16'h0) begin errors++; $display("FAIL err_clear: got %h exp 0", obs()[15:0]); end
        end
    endtask

    task automatic test_stall();
        int cyc;
        trav(8'hA0, 8'hB0, 2, 2, 100, 3, 0, cyc);
        checks++;
        if (cyc !== 2 + 4 + 1 + 1 + 3) begin errors++; $display("FAIL stall_latency: got %0d exp 11", cyc); end
    endtask

    task automatic test_abort_wrap();
        int cyc;
        trav(8'h30, 8'h40, 3, 3, 100, 0, 1, cyc);
        trav(8'h30, 8'h40, 3, 3, 100, 0, 0, cyc);
        checks++;
        if (cyc !== 2 + 9 + 2 + 1) begin errors++; $display("FAIL restart_latency: got %0d exp 14", cyc); end
    endtask

    task automatic test_rst_mid();
        int cyc;
        cyc = 0;
        for (int k = 0; k < 20 && cyc != -1; k++) trav(8'h55, 8'h66, 4, 4, 100, 0, 3, cyc);
        trav(8'h77, 8'h88, 1, 1, 100, 0, 0, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL rst_restart_latency: got %0d exp 4", cyc); end
    endtask

    task automatic test_boundaries();
        int cyc;
        trav(8'hF8, 8'h03, 1, 255, 100, 0, 0, cyc);
        checks++;
        if (cyc !== 2 + 255 + 1) begin errors++; $display("FAIL wide_latency: got %0d exp 258", cyc); end
        trav(8'h02, 8'hFE, 255, 1, 100, 0, 0, cyc);
        checks++;
        if (cyc !== 2 + 255 + 254 + 1) begin errors++; $display("FAIL tall_latency: got %0d exp 512", cyc); end
    endtask

    task automatic test_random();
        int cyc, R, C, pct, mode;
        for (int k = 0; k < 16; k++) begin
            R = $urandom_range(1, 6); C = $urandom_range(1, 6);
            pct = $urandom_range(30, 100);
            mode = ($urandom_range(3) == 0) ? 2 : 0;
            trav(8'($urandom), 8'($urandom), R, C, pct, 0, mode, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int k = 0; k < 3; k++) begin
            trav(8'(k * 16), 8'(k * 32 + 1), k + 2, 3 - k, 100, 0, 0, cyc);
            checks++;
            if (cyc !== 2 + (k + 2) * (3 - k) + (k + 1) + 1) begin
                errors++; $display("FAIL b2b_latency: got %0d exp %0d", cyc, 2 + (k + 2) * (3 - k) + (k + 1) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err();
        test_stall();
        test_abort_wrap();
        test_rst_mid();
        test_boundaries();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
